rv64g_l1_vec_req_queue: RTL and testbench

//  Buffers vector-lane L1 requests and presents the head entry to the per-bank 2:1 arbiter's vector

---
 rtl/rv64g_l1_vec_req_queue_pkg.sv | 35 +++
 rtl/rv64g_l1_vec_req_fifo.sv | 69 ++++++
 rtl/rv64g_l1_vec_req_queue.sv | 142 ++++++++++++++
 tb/tb_rv64g_l1_vec_req_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv64g_l1_vec_req_queue_pkg.sv
// Shared vector-request layout and queue defaults for the L1 vector request path.
// Used by the vector lane, the bank top and rv64g_l1_vec_req_queue.
package rv64g_l1_vec_req_queue_pkg;

    localparam int VQ_DEPTH      = 4;
    localparam int VQ_ID_W       = 4;
    localparam int VQ_TAG_W      = 53;
    localparam int VQ_INDEX_W    = 5;
    localparam int VQ_STARVE_MAX = 16;

    // Fixed-width request fields
    localparam int VQ_WE_W    = 1;
    localparam int VQ_WORD_W  = 3;
    localparam int VQ_WAY_W   = 3;
    localparam int VQ_BE_W    = 8;
    localparam int VQ_WDATA_W = 64;
    localparam int VQ_STATE_W = 2;

    // Packed layout, MSB to LSB: we, index, word, way, be, wdata, tag, state, id
    localparam int VQ_ID_OFF    = 0;
    localparam int VQ_STATE_OFF = VQ_ID_OFF + VQ_ID_W;
    localparam int VQ_TAG_OFF   = VQ_STATE_OFF + VQ_STATE_W;
    localparam int VQ_WDATA_OFF = VQ_TAG_OFF + VQ_TAG_W;
    localparam int VQ_BE_OFF    = VQ_WDATA_OFF + VQ_WDATA_W;
    localparam int VQ_WAY_OFF   = VQ_BE_OFF + VQ_BE_W;
    localparam int VQ_WORD_OFF  = VQ_WAY_OFF + VQ_WAY_W;
    localparam int VQ_INDEX_OFF = VQ_WORD_OFF + VQ_WORD_W;
    localparam int VQ_WE_OFF    = VQ_INDEX_OFF + VQ_INDEX_W;

    function automatic int vq_payload_w(input int index_w, input int tag_w, input int id_w);
        return VQ_WE_W + index_w + VQ_WORD_W + VQ_WAY_W + VQ_BE_W + VQ_WDATA_W
               + tag_w + VQ_STATE_W + id_w;
    endfunction

endpackage

// File: rtl/rv64g_l1_vec_req_fifo.sv
// Generic DEPTH x W FIFO with wrapping pointers and a separate occupancy counter.
// Storage is not reset; flush clears pointers and occupancy synchronously.
module rv64g_l1_vec_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [OCC_W-1:0] occupancy
);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    assign full_s  = (occ_r == OCC_W'(DEPTH));
    assign empty_s = (occ_r == OCC_W'(0));
    // A push in the flush cycle is dropped
    assign push_s  = push & ~full_s & ~flush;
    assign pop_s   = pop & ~empty_s;

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            occ_r    <= OCC_W'(0);
        end else if (flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            occ_r    <= OCC_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            occ_r <= occ_r + OCC_W'(push_s) - OCC_W'(pop_s);
        end
    end

    // Entry storage write
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata     = mem_r[rd_ptr_r];
    assign full      = full_s;
    assign empty     = empty_s;
    assign occupancy = occ_r;

endmodule

// File: rtl/rv64g_l1_vec_req_queue.sv
// Per-bank vector request queue: holds the head against arbiter stalls, emits in-order completions.
// Optional starvation flag is built only when RV64G_L1_VEC_STARVE_GUARD_EN is defined.
module rv64g_l1_vec_req_queue
    import rv64g_l1_vec_req_queue_pkg::*;
#(
    parameter int TAG_W      = VQ_TAG_W,
    parameter int INDEX_W    = VQ_INDEX_W,
    parameter int DEPTH      = VQ_DEPTH,
    parameter int ID_W       = VQ_ID_W,
    parameter int STARVE_MAX = VQ_STARVE_MAX,
    localparam int OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               in_we_i,
    input  logic [INDEX_W-1:0] in_index_i,
    input  logic [2:0]         in_word_i,
    input  logic [2:0]         in_way_i,
    input  logic [7:0]         in_be_i,
    input  logic [63:0]        in_wdata_i,
    input  logic [TAG_W-1:0]   in_tag_i,
    input  logic [1:0]         in_state_i,
    input  logic [ID_W-1:0]    in_id_i,
    output logic               vec_req_o,
    output logic               vec_we_o,
    output logic [INDEX_W-1:0] vec_index_o,
    output logic [2:0]         vec_word_o,
    output logic [2:0]         vec_way_o,
    output logic [7:0]         vec_be_o,
    output logic [63:0]        vec_wdata_o,
    output logic [TAG_W-1:0]   vec_tag_o,
    output logic [1:0]         vec_state_o,
    input  logic               vec_stall_i,
    output logic               done_valid_o,
    output logic [ID_W-1:0]    done_id_o,
    output logic               done_we_o,
    output logic [OCC_W-1:0]   occupancy_o,
    output logic               starve_o
);

    localparam int PW = vq_payload_w(INDEX_W, TAG_W, ID_W);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_param_check
        $error("rv64g_l1_vec_req_queue: DEPTH must be a power of two >= 2, STARVE_MAX >= 1");
    end

    logic [PW-1:0]   wdata_s;
    logic [PW-1:0]   head_s;
    logic [ID_W-1:0] head_id_s;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic            done_valid_r;
    logic [ID_W-1:0] done_id_r;
    logic            done_we_r;

    assign wdata_s = {in_we_i, in_index_i, in_word_i, in_way_i, in_be_i,
                      in_wdata_i, in_tag_i, in_state_i, in_id_i};
    assign {vec_we_o, vec_index_o, vec_word_o, vec_way_o, vec_be_o,
            vec_wdata_o, vec_tag_o, vec_state_o, head_id_s} = head_s;

    // Ready depends only on registered occupancy, never on the stall path
    assign push_s     = in_valid_i & ~full_s;
    assign in_ready_o = ~full_s;
    assign vec_req_o  = ~empty_s;
    assign pop_s      = ~empty_s & ~vec_stall_i;

    rv64g_l1_vec_req_fifo #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flush     (flush_i),
        .push      (push_s),
        .pop       (pop_s),
        .wdata     (wdata_s),
        .rdata     (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .occupancy (occupancy_o)
    );

    // Completion pulse; a pop in the flush cycle still completes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_valid_r <= 1'b0;
            done_id_r    <= ID_W'(0);
            done_we_r    <= 1'b0;
        end else begin
            done_valid_r <= pop_s;
            if (pop_s) begin
                done_id_r <= head_id_s;
                done_we_r <= vec_we_o;
            end
        end
    end

    assign done_valid_o = done_valid_r;
    assign done_id_o    = done_id_r;
    assign done_we_o    = done_we_r;

`ifdef RV64G_L1_VEC_STARVE_GUARD_EN
    localparam int SCNT_W = $clog2(STARVE_MAX + 1);

    logic [SCNT_W-1:0] scnt_r;
    logic [SCNT_W-1:0] scnt_next_s;
    logic              starve_r;

    // Saturating count of consecutive stalled cycles of the current head
    always_comb begin
        scnt_next_s = scnt_r;
        if (flush_i || pop_s || empty_s) begin
            scnt_next_s = SCNT_W'(0);
        end else if (vec_stall_i && (scnt_r != SCNT_W'(STARVE_MAX))) begin
            scnt_next_s = scnt_r + SCNT_W'(1);
        end else begin
            scnt_next_s = scnt_r;
        end
    end

    // Counter and registered starvation flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scnt_r   <= SCNT_W'(0);
            starve_r <= 1'b0;
        end else begin
            scnt_r   <= scnt_next_s;
            starve_r <= (scnt_next_s == SCNT_W'(STARVE_MAX));
        end
    end

    assign starve_o = starve_r;
`else
    assign starve_o = 1'b0;
`endif

endmodule

// File: tb/tb_rv64g_l1_vec_req_queue.sv
// Scoreboard bench for rv64g_l1_vec_req_queue: a reference queue model predicts head/occupancy
// each cycle and pushes expected completions that an independent monitor checks.
module tb_rv64g_l1_vec_req_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        in_we_i;
    logic [4:0]  in_index_i;
    logic [2:0]  in_word_i;
    logic [2:0]  in_way_i;
    logic [7:0]  in_be_i;
    logic [63:0] in_wdata_i;
    logic [52:0] in_tag_i;
    logic [1:0]  in_state_i;
    logic [3:0]  in_id_i;
    logic        vec_req_o;
    logic        vec_we_o;
    logic [4:0]  vec_index_o;
    logic [2:0]  vec_word_o;
    logic [2:0]  vec_way_o;
    logic [7:0]  vec_be_o;
    logic [63:0] vec_wdata_o;
    logic [52:0] vec_tag_o;
    logic [1:0]  vec_state_o;
    logic        vec_stall_i;
    logic        done_valid_o;
    logic [3:0]  done_id_o;
    logic        done_we_o;
    logic [2:0]  occupancy_o;
    logic        starve_o;

    int total = 0;
    int bad   = 0;
    logic [3:0] model_q[$];
    logic [3:0] exp_q[$];
    int scnt = 0;

    always #5 clk_i = ~clk_i;

    rv64g_l1_vec_req_queue dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_we_i(in_we_i),
        .in_index_i(in_index_i), .in_word_i(in_word_i), .in_way_i(in_way_i),
        .in_be_i(in_be_i), .in_wdata_i(in_wdata_i), .in_tag_i(in_tag_i),
        .in_state_i(in_state_i), .in_id_i(in_id_i),
        .vec_req_o(vec_req_o), .vec_we_o(vec_we_o), .vec_index_o(vec_index_o),
        .vec_word_o(vec_word_o), .vec_way_o(vec_way_o), .vec_be_o(vec_be_o),
        .vec_wdata_o(vec_wdata_o), .vec_tag_o(vec_tag_o), .vec_state_o(vec_state_o),
        .vec_stall_i(vec_stall_i), .done_valid_o(done_valid_o), .done_id_o(done_id_o),
        .done_we_o(done_we_o), .occupancy_o(occupancy_o), .starve_o(starve_o)
    );

    // Field patterns derived from the request ID
    function automatic logic        f_we(input logic [3:0] id);    return id[0]; endfunction
    function automatic logic [4:0]  f_index(input logic [3:0] id); return {id, ~id[0]}; endfunction
    function automatic logic [2:0]  f_word(input logic [3:0] id);  return id[2:0]; endfunction
    function automatic logic [2:0]  f_way(input logic [3:0] id);   return ~id[2:0]; endfunction
    function automatic logic [7:0]  f_be(input logic [3:0] id);    return {id, ~id}; endfunction
    function automatic logic [63:0] f_wdata(input logic [3:0] id); return {16{id}}; endfunction
    function automatic logic [52:0] f_tag(input logic [3:0] id);   return {1'b1, {13{id}}}; endfunction
    function automatic logic [1:0]  f_state(input logic [3:0] id); return id[1:0]; endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion monitor
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (done_valid_o) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_spurious: got id %0h expected no pulse at %0t", done_id_o, $time);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    chk("done_id", 128'(done_id_o), 128'(e));
                    chk("done_we", 128'(done_we_o), 128'(f_we(e)));
                end
            end else if (exp_q.size() != 0) begin
                total++;
                bad++;
                $display("FAIL done_missing: got no pulse expected id %0h at %0t", exp_q[0], $time);
                void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus with model prediction and pre-edge output checks
    task automatic cycle(input bit v, input logic [3:0] id, input bit st, input bit fl);
        bit push_ok;
        bit pop_ok;
        bit was_empty;
        in_valid_i = v;
        in_id_i    = id;
        in_we_i    = f_we(id);
        in_index_i = f_index(id);
        in_word_i  = f_word(id);
        in_way_i   = f_way(id);
        in_be_i    = f_be(id);
        in_wdata_i = f_wdata(id);
        in_tag_i   = f_tag(id);
        in_state_i = f_state(id);
        vec_stall_i = st;
        flush_i    = fl;
        @(negedge clk_i);
        #1;
        chk("in_ready", 128'(in_ready_o), 128'(model_q.size() < 4));
        chk("vec_req", 128'(vec_req_o), 128'(model_q.size() > 0));
        chk("occupancy", 128'(occupancy_o), 128'(model_q.size()));
        chk("starve", 128'(starve_o), 128'(scnt == 16));
        if (model_q.size() > 0) begin
            chk("head_we", 128'(vec_we_o), 128'(f_we(model_q[0])));
            chk("head_index", 128'(vec_index_o), 128'(f_index(model_q[0])));
            chk("head_word", 128'(vec_word_o), 128'(f_word(model_q[0])));
            chk("head_way", 128'(vec_way_o), 128'(f_way(model_q[0])));
            chk("head_be", 128'(vec_be_o), 128'(f_be(model_q[0])));
            chk("head_wdata", 128'(vec_wdata_o), 128'(f_wdata(model_q[0])));
            chk("head_tag", 128'(vec_tag_o), 128'(f_tag(model_q[0])));
            chk("head_state", 128'(vec_state_o), 128'(f_state(model_q[0])));
        end
        was_empty = (model_q.size() == 0);
        push_ok = v && (model_q.size() < 4) && !fl;
        pop_ok  = !was_empty && !st;
        @(posedge clk_i);
        if (pop_ok) exp_q.push_back(model_q.pop_front());
        if (fl) model_q.delete();
        else if (push_ok) model_q.push_back(id);
`ifdef RV64G_L1_VEC_STARVE_GUARD_EN
        if (fl || pop_ok || was_empty) scnt = 0;
        else if (st && scnt < 16) scnt++;
`else
        scnt = 0;
`endif
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_ni = 1'b0;
        in_valid_i = 1'b0; in_id_i = 4'h0; in_we_i = 1'b0; in_index_i = 5'h0;
        in_word_i = 3'h0; in_way_i = 3'h0; in_be_i = 8'h0; in_wdata_i = 64'h0;
        in_tag_i = 53'h0; in_state_i = 2'h0; vec_stall_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_occupancy", 128'(occupancy_o), 128'(0));
        chk("rst_vec_req", 128'(vec_req_o), 128'(0));
        chk("rst_done_valid", 128'(done_valid_o), 128'(0));
        chk("rst_done_id", 128'(done_id_o), 128'(0));
        chk("rst_done_we", 128'(done_we_o), 128'(0));
        chk("rst_starve", 128'(starve_o), 128'(0));
        rst_ni = 1'b1;

        // 1: three pushes, no stall
        cycle(1'b1, 4'h1, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0);
        cycle(1'b1, 4'h3, 1'b0, 1'b0);
        idle(3);

        // 2: fill under stall, 5th refused, then drain
        for (int i = 4; i <= 8; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0);
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        idle(6);

        // 3: steady push+pop at occupancy 2 across pointer wrap
        cycle(1'b1, 4'h9, 1'b1, 1'b0);
        cycle(1'b1, 4'hA, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(11 + i), 1'b0, 1'b0);
        idle(4);

        // 4: flush with push and unstalled pop
        cycle(1'b1, 4'h5, 1'b1, 1'b0);
        cycle(1'b1, 4'h6, 1'b1, 1'b0);
        cycle(1'b1, 4'h7, 1'b1, 1'b0);
        cycle(1'b1, 4'hC, 1'b0, 1'b1);
        idle(3);

        // 5: long stall of a single head
        cycle(1'b1, 4'hD, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
        idle(3);

        // 6: asynchronous reset mid-burst at occupancy 3
        cycle(1'b1, 4'h2, 1'b1, 1'b0);
        cycle(1'b1, 4'h4, 1'b1, 1'b0);
        cycle(1'b1, 4'h6, 1'b1, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_occupancy", 128'(occupancy_o), 128'(0));
        chk("arst_vec_req", 128'(vec_req_o), 128'(0));
        chk("arst_done_valid", 128'(done_valid_o), 128'(0));
        chk("arst_starve", 128'(starve_o), 128'(0));
        model_q.delete();
        exp_q.delete();
        scnt = 0;
        vec_stall_i = 1'b0;
        in_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle(4);

        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
